// File: rtl/rr_grant_sequencer_if.sv
// Grant handshake bundle between the round-robin sequencer and its consumer.
//   req           : per-requester level requests (N = 2**IDX_W)
//   grant_ready   : consumer accepts the offered grant
//   grant_idx     : winner index, feeds the one-hot decoder
//   grant_valid   : grant is being offered
//   grant_active  : grant is owned
//   timeout_pulse : one-cycle pulse when a grant is revoked by the hold timeout
//   grant_count   : completed-grant counter (only with RR_GRANT_SEQUENCER_STATS_EN)
// The master modport is the sequencer side; the slave modport is the consumer side.
interface rr_grant_sequencer_if #(
    parameter int IDX_W = 3
);
    localparam int N = 1 << IDX_W;

    logic [N-1:0]     req;
    logic             grant_ready;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             grant_active;
    logic             timeout_pulse;
`ifdef RR_GRANT_SEQUENCER_STATS_EN
    logic [15:0]      grant_count;
`endif

    modport master (
        input  req, grant_ready,
        output grant_idx, grant_valid, grant_active, timeout_pulse
`ifdef RR_GRANT_SEQUENCER_STATS_EN
        , output grant_count
`endif
    );

    modport slave (
        output req, grant_ready,
        input  grant_idx, grant_valid, grant_active, timeout_pulse
`ifdef RR_GRANT_SEQUENCER_STATS_EN
        , input grant_count
`endif
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer for N = 2**IDX_W requesters.
// IDLE picks the first requester scanning circularly from ptr, OFFER presents
// it with grant_valid until accepted (or withdrawn), OWN holds it while its
// request stays high, bounded by MAX_HOLD cycles (0 = no bound). On leaving
// OWN the pointer moves one past the winner.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rr_grant_sequencer_if.master (req/grant_ready in, grant_* out)
// Optional feature macro: RR_GRANT_SEQUENCER_STATS_EN adds a saturating
// 16-bit count of completed grants (bus.grant_count).
module rr_grant_sequencer #(
    parameter int IDX_W    = 3,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    rr_grant_sequencer_if.master   bus
);
    localparam int N = 1 << IDX_W;
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    // hold_cnt value in the last allowed ownership cycle
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OFFER, OWN} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              tmo_nxt;
    logic              valid_q, active_q, tmo_q;
    logic [IDX_W-1:0]  rr_win;
    logic              rr_any;
    logic              win_req;

    assign win_req = bus.req[idx];

    // Circular first-set scan starting at ptr; index arithmetic wraps in IDX_W bits.
    always_comb begin
        rr_any = 1'b0;
        rr_win = ptr;
        for (int i = 0; i < N; i++) begin
            if (!rr_any && bus.req[ptr + IDX_W'(i)]) begin
                rr_any = 1'b1;
                rr_win = ptr + IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        hold_nxt  = hold_cnt;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    idx_nxt   = rr_win;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                // Withdrawal wins over acceptance; pointer stays put.
                if (!win_req) begin
                    state_nxt = IDLE;
                end else if (bus.grant_ready) begin
                    state_nxt = OWN;
                    hold_nxt  = '0;
                end
            end
            OWN: begin
                if (hold_cnt != '1)
                    hold_nxt = hold_cnt + HOLD_W'(1);
                // Release is checked first so a simultaneous release/timeout
                // is a normal release without the pulse.
                if (!win_req) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx + IDX_W'(1);
                end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx + IDX_W'(1);
                    tmo_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx      <= idx_nxt;
            hold_cnt <= hold_nxt;
            valid_q  <= (state_nxt == OFFER);
            active_q <= (state_nxt == OWN);
            tmo_q    <= tmo_nxt;
        end
    end

    assign bus.grant_idx     = idx;
    assign bus.grant_valid   = valid_q;
    assign bus.grant_active  = active_q;
    assign bus.timeout_pulse = tmo_q;

`ifdef RR_GRANT_SEQUENCER_STATS_EN
    logic [15:0] cnt;
    logic        own_exit;

    // Any exit from OWN (release or timeout) completes a grant.
    assign own_exit = (state == OWN) && (state_nxt == IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (own_exit && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

    assign bus.grant_count = cnt;
`endif
endmodule

// File: tb/tb_rr_grant_sequencer.sv
module tb_rr_grant_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [2:0] sb_q[$];
    bit   pv = 1'b0;

    rr_grant_sequencer_if #(.IDX_W(3)) bus();

    rr_grant_sequencer #(.IDX_W(3), .HOLD_W(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input logic [15:0] exp);
`ifdef RR_GRANT_SEQUENCER_STATS_EN
        chk("grant_count", bus.grant_count, exp);
`else
        if (exp == 16'hFFFF) $display("unexpected count %0d", exp);
`endif
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", bus.grant_valid, 0);
        chk("rst_active", bus.grant_active, 0);
        chk("rst_tmo", bus.timeout_pulse, 0);
        chk("rst_idx", bus.grant_idx, 0);
        chk_cnt(16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.grant_ready = 1'b0;
        tick();
        tick();
        chk_reset_outs();
        rst = 1'b0;
    endtask

    // From IDLE with bus.req already set: offer, accept, release, then apply req_after.
    task automatic do_grant(input logic [2:0] exp, input logic [7:0] req_after);
        sb_q.push_back(exp);
        bus.grant_ready = 1'b1;
        tick();
        chk("offer_valid", bus.grant_valid, 1);
        chk("offer_active", bus.grant_active, 0);
        tick();
        chk("own_active", bus.grant_active, 1);
        chk("own_valid", bus.grant_valid, 0);
        bus.req[exp] = 1'b0;
        tick();
        chk("idle_valid", bus.grant_valid, 0);
        chk("idle_active", bus.grant_active, 0);
        chk("idle_tmo", bus.timeout_pulse, 0);
        bus.req = req_after;
    endtask

    // Scoreboard side: every new offer pops the next expected winner.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("valid_active_excl", {31'd0, bus.grant_valid & bus.grant_active}, 0);
            if (bus.grant_valid && !pv) begin
                chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 1);
                if (sb_q.size() != 0)
                    chk("grant_idx", {29'd0, bus.grant_idx}, {29'd0, sb_q.pop_front()});
            end
        end
        pv = bus.grant_valid;
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // single grant of requester 2
        bus.req = 8'b0000_0100;
        do_grant(3'd2, 8'h00);
        chk_cnt(16'd1);

        // all requesting: 0..7 then 0 again
        do_reset();
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++)
            do_grant(3'(g), (g == 8) ? 8'h00 : 8'hFF);
        chk_cnt(16'd9);

        // wrap: grant 6 moves ptr to 7, then 7 beats 0, then 0
        bus.req = 8'b0100_0000;
        do_grant(3'd6, 8'b1000_0001);
        do_grant(3'd7, 8'b1000_0001);
        do_grant(3'd0, 8'h00);
        chk_cnt(16'd12);

        // hold timeout on requester 5 (MAX_HOLD=4)
        bus.req = 8'b0010_0000;
        bus.grant_ready = 1'b1;
        sb_q.push_back(3'd5);
        tick();
        chk("to_offer", bus.grant_valid, 1);
        tick();
        chk("to_active1", bus.grant_active, 1);
        bus.req = 8'b0010_0001;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("to_active", bus.grant_active, 1);
            chk("to_nopulse", bus.timeout_pulse, 0);
        end
        tick();
        chk("to_released", bus.grant_active, 0);
        chk("to_pulse", bus.timeout_pulse, 1);
        chk("to_idle_valid", bus.grant_valid, 0);
        sb_q.push_back(3'd0);
        tick();
        chk("to_next_offer", bus.grant_valid, 1);
        chk("to_pulse_one", bus.timeout_pulse, 0);
        tick();
        chk("to_next_own", bus.grant_active, 1);
        bus.req = 8'b0010_0000;
        tick();
        chk("to_next_rel", bus.grant_active, 0);
        chk("to_next_nopulse", bus.timeout_pulse, 0);
        bus.req = 8'h00;
        chk_cnt(16'd14);

        // withdraw during OFFER: ptr stays at 1, so 2 wins over 0 afterwards
        bus.grant_ready = 1'b0;
        bus.req = 8'b0000_1000;
        sb_q.push_back(3'd3);
        tick();
        chk("wd_offer", bus.grant_valid, 1);
        tick();
        chk("wd_offer_hold", bus.grant_valid, 1);
        chk("wd_idx_stable", bus.grant_idx, 3);
        bus.req = 8'h00;
        tick();
        chk("wd_idle_valid", bus.grant_valid, 0);
        chk("wd_idle_active", bus.grant_active, 0);
        chk_cnt(16'd14);
        bus.req = 8'b0000_0101;
        do_grant(3'd2, 8'h00);
        chk_cnt(16'd15);

        // reset while owning grant 4
        bus.req = 8'b0001_0000;
        bus.grant_ready = 1'b1;
        sb_q.push_back(3'd4);
        tick();
        chk("rs_offer", bus.grant_valid, 1);
        tick();
        chk("rs_own", bus.grant_active, 1);
        chk("rs_own_idx", bus.grant_idx, 4);
        rst = 1'b1;
        tick();
        chk_reset_outs();
        rst = 1'b0;
        bus.req = 8'b0001_0001;
        do_grant(3'd0, 8'h00);
        chk_cnt(16'd1);

        tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
